// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the execute stage; raises stall_req while busy.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and |a|<|b| complete one cycle after start.
//
// state | meaning
// IDLE  | no division in flight
// BUSY  | one restoring step per cycle, WIDTH steps total
// DONE  | result valid, ready pulses for this cycle
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall_req,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, div_q, a_raw;
  logic             q_neg, r_neg, div_zero;

  logic             a_neg_in, b_neg_in, start_ok;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fix, r_fix;
  logic [2*WIDTH-1:0] final_res;

  always_comb begin
    a_neg_in = signed_div & a[WIDTH-1];
    b_neg_in = signed_div & b[WIDTH-1];
    a_mag    = a_neg_in ? (~a + ONE) : a;
    b_mag    = b_neg_in ? (~b + ONE) : b;
    // Restoring step: a borrow out of the trial subtract means keep the shifted remainder.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, div_q};
    rem_nxt  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    q_fix    = q_neg ? (~quo_nxt + ONE) : quo_nxt;
    r_fix    = r_neg ? (~rem_nxt + ONE) : rem_nxt;
    final_res = div_zero ? {a_raw, ONES} : {r_fix, q_fix};
    start_ok  = start & ~annul & ((state == IDLE) | (state == DONE));
    stall_req = start_ok | ((state == BUSY) & ~annul);
  end

`ifdef DIV_EARLY_OUT_EN
  logic b_zero_in, small_in;
  always_comb begin
    b_zero_in = (b == ZERO);
    small_in  = (a_mag < b_mag);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      a_raw    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ready    <= 1'b0;
      result   <= '0;
    end else if (annul) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          ready <= 1'b0;
          if (start) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= a_mag;
            div_q    <= b_mag;
            a_raw    <= a;
            q_neg    <= a_neg_in ^ b_neg_in;
            r_neg    <= a_neg_in;
            div_zero <= (b == ZERO);
            state    <= BUSY;
`ifdef DIV_EARLY_OUT_EN
            if (b_zero_in) begin
              result <= {a, ONES};
              state  <= DONE;
              ready  <= 1'b1;
            end else if (small_in) begin
              result <= {a, ZERO};
              state  <= DONE;
              ready  <= 1'b1;
            end
`endif
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + CNT_ONE;
          if (cnt == LAST) begin
            result <= final_res;
            state  <= DONE;
            ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: vector table plus annul, reset and back-to-back sequences.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        annul = 1'b0;
  logic        stall_req;
  logic        ready;
  logic [63:0] result;

  int total = 0;
  int bad = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a_in), .b(b_in), .annul(annul),
    .stall_req(stall_req), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    bit          early;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input bit early);
`ifdef DIV_EARLY_OUT_EN
    return early ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Called at the falling edge of the first cycle after start; returns the cycle ready was seen.
  task automatic wait_ready(output int n, output int drops);
    n = 1;
    drops = 0;
    while (!ready && n < 100) begin
      if (!stall_req) drops++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string name);
    int n, drops;
    @(negedge clk);
    start = 1'b1; signed_div = sd; a_in = a; b_in = b;
    #1 chk({name, "_stall_start"}, 64'(stall_req), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_ready(n, drops);
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, result, exp);
    chk({name, "_stall_done"}, 64'(stall_req), 64'd0);
    chk({name, "_stall_busy"}, 64'(drops), 64'd0);
    @(negedge clk);
    chk({name, "_ready_pulse"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int n, drops, hits;

    vecs[0]  = '{1'b0, 32'd7,        32'd2,        {32'd1,        32'd3},        1'b0, "divu_7_2"};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, "div_m7_2"};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}, 1'b0, "div_7_m2"};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0,        32'h80000000}, 1'b0, "div_ovf"};
    vecs[4]  = '{1'b0, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF}, 1'b1, "divu_by0"};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},        1'b0, "div_m7_m2"};
    vecs[6]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        {32'd1,        32'h7FFFFFFC}, 1'b0, "divu_big"};
    vecs[7]  = '{1'b1, 32'd3,        32'd7,        {32'd3,        32'd0},        1'b1, "div_small"};
    vecs[8]  = '{1'b1, 32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFD, 32'd0},        1'b1, "div_small_neg"};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9, 32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}, 1'b1, "div_by0_neg"};
    vecs[10] = '{1'b0, 32'd100,      32'd7,        {32'd2,        32'd14},       1'b0, "divu_100_7"};
    vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0,        32'hFFFFFFFF}, 1'b0, "divu_max_1"};
    vecs[12] = '{1'b0, 32'd5,        32'd5,        {32'd0,        32'd1},        1'b0, "divu_eq"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, exp_lat(vecs[i].early), vecs[i].name);

    // Annul mid-division: result must keep the previous value {1,3}.
    run_op(1'b0, 32'd7, 32'd2, {32'd1, 32'd3}, 33, "pre_annul");
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    #1 chk("annul_stall_same", 64'(stall_req), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1 chk("annul_stall_next", 64'(stall_req), 64'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready || stall_req) hits++;
    end
    chk("annul_no_ready", 64'(hits), 64'd0);
    chk("annul_result_kept", result, {32'd1, 32'd3});

    // Annul together with start in IDLE: the start is dropped.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; a_in = 32'd9; b_in = 32'd3;
    #1 chk("annul_start_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready || stall_req) hits++;
    end
    chk("annul_start_idle", 64'(hits), 64'd0);
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "post_annul");

    // Asynchronous reset mid-division.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_result", result, 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "post_rst");

    // Back-to-back: second start issued in the DONE cycle of the first.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a_in = 32'd20; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_ready(n, drops);
    chk("b2b_first_latency", 64'(n), 64'd33);
    chk("b2b_first_result", result, {32'd2, 32'd6});
    chk("b2b_first_stall", 64'(drops), 64'd0);
    start = 1'b1; a_in = 32'd50; b_in = 32'd5;
    #1 chk("b2b_done_stall", 64'(stall_req), 64'd1);
    chk("b2b_done_ready", 64'(ready), 64'd1);
    @(negedge clk);
    start = 1'b0;
    wait_ready(n, drops);
    chk("b2b_second_latency", 64'(n), 64'd33);
    chk("b2b_second_result", result, {32'd0, 32'd10});
    chk("b2b_second_stall", 64'(drops), 64'd0);
    @(negedge clk);
    chk("b2b_ready_pulse", 64'(ready), 64'd0);
    chk("b2b_result_hold", result, {32'd0, 32'd10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the MIPS execute stage. Sits beside the ALU.
- It is the producer of the stall request that the pipeline registers with stall/clear consume; hazard logic ORs `stall_req` into the stall of the IF/ID/EX registers.
- Result is written to HI/LO on `ready`.
- Supports DIV (signed) and DIVU (unsigned) with MIPS truncation semantics.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a new division; sampled when state is IDLE or DONE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- annul  in  1  cancel the in-flight division (exception/flush); highest priority after rst.
- stall_req  out  1  pipeline stall request.
- ready  out  1  one-cycle pulse; result valid and must be written to HI/LO.
- result  out  2*WIDTH  {remainder(HI), quotient(LO)}.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, any state, including mid-division):
  - state=IDLE, iteration counter=0, ready=0, result=0, internal operand registers=0.
  - stall_req=0, since it is derived from state and start.
- IDLE/DONE + start=1 + annul=0:
  - Latch |a|, |b| (magnitudes when signed_div=1, raw when 0).
  - Latch the quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]), both masked by signed_div.
  - Clear the partial remainder; counter=0; go to BUSY.
- IDLE/DONE + start=0: stay in or go to IDLE; ready=0.
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left 1, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
  - After WIDTH steps (counter==WIDTH-1), go to DONE.
  - On the transition edge, load `result` with the sign-corrected values.
  - start is ignored in BUSY.
- DONE: ready=1 for exactly this cycle; result is stable.
- Latency: start sampled at edge N → ready high in cycle N+WIDTH+1 (33 cycles after the start cycle for WIDTH=32).
- stall_req = (start & ~annul & state∈{IDLE,DONE}) | (state==BUSY & ~annul). It is combinational so the start instruction stalls in the same cycle. It is low in DONE unless a back-to-back start is present.
- annul=1:
  - Next edge: state=IDLE.
  - ready stays 0, and result is NOT updated (keeps its prior value).
  - stall_req drops combinationally in the same cycle.
  - start in the same cycle is ignored.
- Signed correction:
  - Quotient negated if the quotient sign is set.
  - Remainder negated if the remainder sign is set.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. This falls out of magnitude arithmetic modulo 2^WIDTH and needs no special case.
- Divide by zero (b==0): quotient all ones, remainder = a (raw, unmodified). This is forced at result load regardless of signed_div. Full latency applies unless the optional feature is compiled in.
- Back-to-back: start during the DONE cycle is accepted. DONE→BUSY directly; ready for the first op is still asserted in that DONE cycle.
- result holds its value until the next completed division or reset.

Optional Feature:
- Macro `DIV_EARLY_OUT_EN`.
- When defined, at start the block checks two cases:
  - b==0: result = {a, all ones}.
  - |a| < |b|: result = {a, 0}, i.e. remainder is the original signed a and quotient is 0.
  - In either case the block goes directly to DONE. ready is high in the cycle after start, and stall_req is high only in the start cycle.
- When undefined, every division takes the full WIDTH+1 cycles; divide-by-zero and small-dividend results are identical in value, only timing differs.

Test Plan:
- DIVU a=7, b=2, start 1 cycle → stall_req high for 33 cycles, ready pulse at cycle 33, result={0x00000001,0x00000003}.
- DIV a=0xFFFFFFF9 (−7), b=2 → result={0xFFFFFFFF,0xFFFFFFFD}; DIV a=7, b=0xFFFFFFFE → result={0x00000001,0xFFFFFFFD}.
- DIV a=0x80000000, b=0xFFFFFFFF → result={0x00000000,0x80000000}; DIVU a=0x12345678, b=0 → result={0x12345678,0xFFFFFFFF}. With DIV_EARLY_OUT_EN, ready comes 1 cycle after start.
- Start DIVU 100/7, assert annul at cycle 10 → stall_req low the same cycle, state IDLE next cycle, no ready, result keeps prior value. A new start of 100/7 then gives {2, 14}.
- Start a division, assert rst at cycle 15 → all outputs 0 immediately (async). After release, start of 9/3 gives {0,3} with normal latency.
- Back-to-back: 20/3 completes; start 50/5 in the DONE cycle → ready for {2,6}, then a second ready 33 cycles later with {0,10}, stall_req continuous except in the first DONE cycle where start keeps it high.
